// File: rtl/cnt_seq_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seq_checker_pkg
//  Description : Shared types and constants for the decimal counter sequence
//                checker: FSM state encoding, error cause codes, digit range.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnt_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_SKIP  = 2'd2;
    localparam logic [1:0] ERR_STALL = 2'd3;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Successor of a decimal digit; 9 rolls over to 0.
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_hold_timer
//  Description : Counts consecutive hold samples of the tracked digit and
//                flags a stall on the hold that would exceed HOLD_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_hold_timer #(
    parameter int HOLD_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,    // legal advance or error clear
    input  logic i_hold,   // legal hold sample this cycle
    output logic o_stall   // this hold is one too many
);

    localparam int HOLD_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    // A hold arriving with the counter already at the limit is the stall.
    assign o_stall = i_hold && (hold_cnt_q == C_HOLD_LIMIT);

    // Next count: clear wins, otherwise count holds that are not the stall.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (i_clr) begin
            hold_cnt_d = '0;
        end else if (i_hold && !o_stall) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seq_checker
//  Description : Watches the digit stream of a 0-9 counter, locks onto it,
//                flags range/skip/stall errors (sticky until clr_err) and
//                counts observed 9->0 wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_seq_checker
    import cnt_seq_checker_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              vld_in,
    input  logic              clr_err,
    output logic              lock,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_pulse
);

    state_t            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;

    logic w_tracking;
    logic w_in_range;
    logic w_hold;
    logic w_advance;
    logic w_stall;
    logic w_timer_clr;

    // Sample classification while tracking; prev is always a legal digit,
    // so equality with prev or its successor implies cnt_in is in range.
    assign w_tracking  = vld_in && (state_q == ST_TRACK);
    assign w_in_range  = (cnt_in <= DIGIT_MAX);
    assign w_hold      = w_tracking && (cnt_in == prev_q);
    assign w_advance   = w_tracking && (cnt_in == next_digit(prev_q));
    assign w_timer_clr = w_advance || ((state_q == ST_ERR) && clr_err);

    cnt_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_timer_clr),
        .i_hold  (w_hold),
        .o_stall (w_stall)
    );

    // Next-state and output decode; every register holds unless a valid
    // sample (or clr_err in ERR) moves it.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        err_code_d   = err_code_q;
        wrap_cnt_d   = wrap_cnt_q;
        wrap_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vld_in) begin
                    if (!w_in_range) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_RANGE;
                    end else begin
                        state_d = ST_TRACK;
                        prev_d  = cnt_in;
                    end
                end
            end
            ST_TRACK: begin
                if (vld_in) begin
                    if (!w_in_range) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_RANGE;
                    end else if (w_hold) begin
                        if (w_stall) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_STALL;
                        end
                    end else if (w_advance) begin
                        prev_d = cnt_in;
                        if (prev_q == DIGIT_MAX) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_cnt_q != '1) begin
                                wrap_cnt_d = wrap_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_SKIP;
                    end
                end
            end
            ST_ERR: begin
                // Sticky: samples are ignored, only clr_err leaves.
                if (clr_err) begin
                    state_d    = ST_IDLE;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                err_code_d = ERR_NONE;
            end
        endcase
        lock_d = (state_d == ST_TRACK);
        err_d  = (state_d == ST_ERR);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= 4'd0;
            err_code_q   <= ERR_NONE;
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            err_code_q   <= err_code_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
        end
    end

    assign lock       = lock_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_seq_checker
//  Description : Self-checking bench for cnt_seq_checker. Instance A uses the
//                default parameters, instance B uses HOLD_MAX=3, WRAP_W=2;
//                both see the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld_in = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] cnt_in = 4'd0;

    logic       a_lock, a_err, a_wp;
    logic [1:0] a_code;
    logic [7:0] a_wc;
    logic       b_lock, b_err, b_wp;
    logic [1:0] b_code;
    logic [1:0] b_wc;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cnt_seq_checker u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .vld_in     (vld_in),
        .clr_err    (clr_err),
        .lock       (a_lock),
        .err        (a_err),
        .err_code   (a_code),
        .wrap_cnt   (a_wc),
        .wrap_pulse (a_wp)
    );

    cnt_seq_checker #(
        .HOLD_MAX (3),
        .WRAP_W   (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .vld_in     (vld_in),
        .clr_err    (clr_err),
        .lock       (b_lock),
        .err        (b_err),
        .err_code   (b_code),
        .wrap_cnt   (b_wc),
        .wrap_pulse (b_wp)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic       clr;
        logic [3:0] cnt;
        logic       lock;
        logic       err;
        logic [1:0] code;
        logic [7:0] wc;
        logic       wp;
        int         phase;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic c, input logic [3:0] d,
                       input logic l, input logic e, input logic [1:0] ec,
                       input logic [7:0] w, input logic p, input int ph);
        vec_t t;
        t.rst = r; t.vld = v; t.clr = c; t.cnt = d;
        t.lock = l; t.err = e; t.code = ec; t.wc = w; t.wp = p; t.phase = ph;
        tbl.push_back(t);
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input logic c, input logic [3:0] d);
        rst = r; vld_in = v; clr_err = c; cnt_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string nm, input int idx, input logic l, input logic e,
                           input logic [1:0] ec, input logic [7:0] w, input logic p);
        n_vec++;
        if ({a_lock, a_err, a_code, a_wc, a_wp} !== {l, e, ec, w, p}) begin
            n_miss++;
            $display("FAIL %s[%0d]: got lock=%b err=%b code=%0d wrap_cnt=%0d pulse=%b, want lock=%b err=%b code=%0d wrap_cnt=%0d pulse=%b",
                     nm, idx, a_lock, a_err, a_code, a_wc, a_wp, l, e, ec, w, p);
        end
    endtask

    task automatic check_b(input string nm, input int idx, input logic l, input logic e,
                           input logic [1:0] ec, input logic [1:0] w, input logic p);
        n_vec++;
        if ({b_lock, b_err, b_code, b_wc, b_wp} !== {l, e, ec, w, p}) begin
            n_miss++;
            $display("FAIL %s[%0d]: got lock=%b err=%b code=%0d wrap_cnt=%0d pulse=%b, want lock=%b err=%b code=%0d wrap_cnt=%0d pulse=%b",
                     nm, idx, b_lock, b_err, b_code, b_wc, b_wp, l, e, ec, w, p);
        end
    endtask

    initial begin
        int pulses;
        int wexp;

        // ---- table: phase 1, reset then clean 0..9,0..9,0 ----
        add(1, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 1);
        for (int i = 0; i <= 20; i++) begin
            add(0, 1, 0, 4'(i % 10), 1, 0, 2'd0,
                8'((i >= 20) ? 2 : (i >= 10) ? 1 : 0), (i == 10) || (i == 20), 1);
        end
        // ---- phase 2, skip 3,4,6; sticky ERR; clr_err with illegal sample ----
        add(1, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 2);
        add(0, 1, 0, 4'd3, 1, 0, 2'd0, 8'd0, 0, 2);
        add(0, 1, 0, 4'd4, 1, 0, 2'd0, 8'd0, 0, 2);
        add(0, 1, 0, 4'd6, 0, 1, 2'd2, 8'd0, 0, 2);
        add(0, 1, 0, 4'd7, 0, 1, 2'd2, 8'd0, 0, 2);
        add(0, 0, 0, 4'd0, 0, 1, 2'd2, 8'd0, 0, 2);
        add(0, 1, 1, 4'd9, 0, 0, 2'd0, 8'd0, 0, 2);
        add(0, 1, 0, 4'd5, 1, 0, 2'd0, 8'd0, 0, 2);
        add(0, 1, 1, 4'd6, 1, 0, 2'd0, 8'd0, 0, 2);
        // ---- phase 3, range in IDLE and TRACK; reset overrides inputs ----
        add(1, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 3);
        add(0, 0, 1, 4'd0, 0, 0, 2'd0, 8'd0, 0, 3);
        add(0, 1, 0, 4'd12, 0, 1, 2'd1, 8'd0, 0, 3);
        add(0, 0, 1, 4'd0, 0, 0, 2'd0, 8'd0, 0, 3);
        add(0, 1, 0, 4'd5, 1, 0, 2'd0, 8'd0, 0, 3);
        add(0, 1, 0, 4'd11, 0, 1, 2'd1, 8'd0, 0, 3);
        add(1, 1, 1, 4'd3, 0, 0, 2'd0, 8'd0, 0, 3);
        add(0, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 3);
        // ---- phase 4, 0..9,0 with an idle gap after every sample ----
        for (int i = 0; i <= 10; i++) begin
            add(0, 1, 0, 4'(i % 10), 1, 0, 2'd0, 8'((i == 10) ? 1 : 0), i == 10, 4);
            add(0, 0, 0, 4'hf, 1, 0, 2'd0, 8'((i == 10) ? 1 : 0), 0, 4);
        end
        // ---- phase 5, run up to wrap_cnt=4 then reset mid-TRACK / mid-ERR ----
        for (int w = 2; w <= 4; w++) begin
            for (int d = 1; d <= 9; d++) begin
                add(0, 1, 0, 4'(d), 1, 0, 2'd0, 8'(w - 1), 0, 5);
            end
            add(0, 1, 0, 4'd0, 1, 0, 2'd0, 8'(w), 1, 5);
        end
        add(1, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 5);
        add(0, 1, 0, 4'd10, 0, 1, 2'd1, 8'd0, 0, 5);
        add(1, 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0, 5);
        add(0, 1, 0, 4'd4, 1, 0, 2'd0, 8'd0, 0, 5);
        add(0, 1, 0, 4'd5, 1, 0, 2'd0, 8'd0, 0, 5);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst, tbl[k].vld, tbl[k].clr, tbl[k].cnt);
            check_a($sformatf("table_p%0d", tbl[k].phase), k, tbl[k].lock, tbl[k].err,
                    tbl[k].code, tbl[k].wc, tbl[k].wp);
        end

        // ---- stall on default instance: 1 entry + 15 holds fine, 16th hold errs ----
        drive(1, 0, 0, 4'd0);
        drive(0, 1, 0, 4'd7);
        check_a("stall_a_entry", 0, 1, 0, 2'd0, 8'd0, 0);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 1, 0, 4'd7);
            check_a("stall_a_hold", k, 1, 0, 2'd0, 8'd0, 0);
        end
        drive(0, 1, 0, 4'd7);
        check_a("stall_a_err", 16, 0, 1, 2'd3, 8'd0, 0);

        // ---- stall on HOLD_MAX=3 instance ----
        drive(1, 0, 0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 4'd7);
            check_b("stall_b_ok", k, 1, 0, 2'd0, 2'd0, 0);
        end
        drive(0, 1, 0, 4'd7);
        check_b("stall_b_err", 4, 0, 1, 2'd3, 2'd0, 0);
        drive(0, 0, 1, 4'd0);
        check_b("stall_b_clr", 0, 0, 0, 2'd0, 2'd0, 0);
        // a legal advance restarts the hold budget
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, (k < 4) ? 4'd2 : 4'd3);
            check_b("stall_b_restart", k, 1, 0, 2'd0, 2'd0, 0);
        end
        drive(0, 1, 0, 4'd3);
        check_b("stall_b_err2", 8, 0, 1, 2'd3, 2'd0, 0);

        // ---- wrap saturation on WRAP_W=2 instance: 5 wraps ----
        drive(1, 0, 0, 4'd0);
        drive(0, 1, 0, 4'd9);
        check_b("sat_entry", 0, 1, 0, 2'd0, 2'd0, 0);
        pulses = 0;
        for (int w = 1; w <= 5; w++) begin
            for (int d = 0; d <= 9; d++) begin
                drive(0, 1, 0, 4'(d));
                if (b_wp) pulses++;
                wexp = (w > 3) ? 3 : w;
                check_b("sat_step", w * 10 + d, 1, 0, 2'd0, 2'(wexp), d == 0);
            end
        end
        n_vec++;
        if (pulses != 5) begin
            n_miss++;
            $display("FAIL sat_pulse_count: got %0d pulses, want 5", pulses);
        end
        drive(1, 0, 0, 4'd0);
        check_b("sat_reset", 0, 0, 0, 2'd0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
